// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_sync
//  Description : SPI mode-0 slave running in the system clock domain.
//                Oversamples sclk/ss/mosi through 2-FF synchronisers, shifts
//                MSB-first, one-entry tx buffer with valid/ready handshake,
//                one-cycle rx_valid pulse per completed word, multi-word bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_sync #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  tx_underrun,
    output logic                  frame_err
);

    localparam int                 c_CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DATA_WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Synchroniser and edge-detect flops
    logic r_sclk_m, r_sclk_s, r_sclk_d;
    logic r_ss_m,   r_ss_s,   r_ss_d;
    logic r_mosi_m, r_mosi_s;

    // Datapath registers
    logic [DATA_WIDTH-1:0] r_tx_buf;
    logic                  r_buf_full;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic [DATA_WIDTH-2:0] r_rx_shift;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_tx_underrun;
    logic                  r_frame_err;

    // Decoded edges and per-cycle control strobes
    logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
    logic w_word_start, w_bit_rise, w_last_rise, w_bit_fall, w_frame_end, w_abort;
    logic w_tx_write;

    assign w_sclk_rise = r_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s & r_sclk_d;
    assign w_ss_fall   = ~r_ss_s & r_ss_d;
    assign w_ss_rise   = r_ss_s & ~r_ss_d;

    // Buffer can accept a word only when empty and out of reset
    assign tx_ready   = rst & ~r_buf_full;
    assign w_tx_write = tx_valid & tx_ready;

    assign miso        = r_tx_shift[DATA_WIDTH-1];
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign busy        = (r_state == ST_SHIFT);
    assign tx_underrun = r_tx_underrun;
    assign frame_err   = r_frame_err;

    // Bring the asynchronous SPI pins into the clk domain; ss idles high
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sclk_m <= 1'b0;
            r_sclk_s <= 1'b0;
            r_sclk_d <= 1'b0;
            r_ss_m   <= 1'b1;
            r_ss_s   <= 1'b1;
            r_ss_d   <= 1'b1;
            r_mosi_m <= 1'b0;
            r_mosi_s <= 1'b0;
        end else begin
            r_sclk_m <= sclk;
            r_sclk_s <= r_sclk_m;
            r_sclk_d <= r_sclk_s;
            r_ss_m   <= ss;
            r_ss_s   <= r_ss_m;
            r_ss_d   <= r_ss_s;
            r_mosi_m <= mosi;
            r_mosi_s <= r_mosi_m;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode; an ss rise outranks any same-cycle sclk edge
    always_comb begin
        w_next_state = r_state;
        w_word_start = 1'b0;
        w_bit_rise   = 1'b0;
        w_last_rise  = 1'b0;
        w_bit_fall   = 1'b0;
        w_frame_end  = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ss_fall) begin
                    w_next_state = ST_SHIFT;
                    w_word_start = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (w_ss_rise) begin
                    w_next_state = ST_IDLE;
                    w_frame_end  = 1'b1;
                    w_abort      = (r_bit_cnt != '0) && (r_bit_cnt < c_CNT_FULL);
                end else if (w_sclk_rise) begin
                    w_bit_rise  = (r_bit_cnt < c_CNT_FULL);
                    w_last_rise = (r_bit_cnt == c_CNT_LAST);
                end else if (w_sclk_fall) begin
                    if (r_bit_cnt == c_CNT_FULL) begin
                        w_word_start = 1'b1;
                    end else begin
                        w_bit_fall = 1'b1;
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: tx buffer, shift registers, bit counter and status pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_buf      <= '0;
            r_buf_full    <= 1'b0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_bit_cnt     <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_frame_err   <= 1'b0;

            // Write only into an empty buffer; a load never coincides with it
            if (w_tx_write) begin
                r_tx_buf   <= tx_data;
                r_buf_full <= 1'b1;
            end

            if (w_word_start) begin
                r_bit_cnt  <= '0;
                r_rx_shift <= '0;
                if (r_buf_full) begin
                    r_tx_shift <= r_tx_buf;
                    r_buf_full <= 1'b0;
                end else begin
                    r_tx_shift    <= DEFAULT_TX;
                    r_tx_underrun <= 1'b1;
                end
            end

            if (w_bit_rise) begin
                r_rx_shift <= {r_rx_shift[DATA_WIDTH-3:0], r_mosi_s};
                r_bit_cnt  <= r_bit_cnt + 1'b1;
                if (w_last_rise) begin
                    r_rx_data  <= {r_rx_shift, r_mosi_s};
                    r_rx_valid <= 1'b1;
                end
            end

            if (w_bit_fall) begin
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end

            // Leaving the frame: release miso, drop any partial word
            if (w_frame_end) begin
                r_tx_shift  <= '0;
                r_rx_shift  <= '0;
                r_bit_cnt   <= '0;
                r_frame_err <= w_abort;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_sync.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spi_slave_sync
//  Description : Directed self-checking bench for spi_slave_sync; acts as an
//                SPI mode-0 master and counts status pulses from the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_sync;

    localparam int H = 80;   // sclk half period, 8 clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b0;
    logic       ss = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       tx_underrun;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;

    int rv_cnt = 0;
    int ur_cnt = 0;
    int fe_cnt = 0;
    logic [7:0] rx_log [8];

    logic [7:0] m_words [4];
    logic [7:0] s_words [4];

    int rv0, ur0, fe0;
    logic r_dummy;

    spi_slave_sync #(
        .DATA_WIDTH (8),
        .DEFAULT_TX (8'hFF)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .ss          (ss),
        .mosi        (mosi),
        .miso        (miso),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .tx_underrun (tx_underrun),
        .frame_err   (frame_err)
    );

    // 100 MHz system clock
    always #5 clk = ~clk;

    // Count status pulses and log received words away from the active edge
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rv_cnt % 8] <= rx_data;
            rv_cnt <= rv_cnt + 1;
        end
        if (tx_underrun) ur_cnt <= ur_cnt + 1;
        if (frame_err)   fe_cnt <= fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // One full sclk cycle: present mosi, rise, sample miso, fall
    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        #(H);
        sclk = 1'b1;
        r = miso;
        #(H);
        sclk = 1'b0;
    endtask

    // Frame of nwords words; ss rises before the final sclk fall
    task automatic spi_frame(input int nwords);
        ss = 1'b0;
        for (int w = 0; w < nwords; w++) begin
            for (int i = 7; i >= 0; i--) begin
                mosi = m_words[w][i];
                #(H);
                sclk = 1'b1;
                s_words[w][i] = miso;
                #(H);
                if (w == nwords - 1 && i == 0) begin
                    ss = 1'b1;
                    #(H);
                end
                sclk = 1'b0;
            end
        end
        #(H);
    endtask

    task automatic snap();
        rv0 = rv_cnt;
        ur0 = ur_cnt;
        fe0 = fe_cnt;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_miso",     {31'd0, miso},        32'd0);
        check("rst_rx_data",  {24'd0, rx_data},     32'd0);
        check("rst_rx_valid", {31'd0, rx_valid},    32'd0);
        check("rst_busy",     {31'd0, busy},        32'd0);
        check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
        check("rst_frame_err",{31'd0, frame_err},   32'd0);
        check("rst_tx_ready", {31'd0, tx_ready},    32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rel_tx_ready", {31'd0, tx_ready},    32'd1);

        // Loaded word 0xA5, master sends 0x12
        tx_write(8'hA5);
        check("t1_ready_full", {31'd0, tx_ready}, 32'd0);
        snap();
        m_words[0] = 8'h12;
        spi_frame(1);
        check("t1_miso",     {24'd0, s_words[0]},  32'hA5);
        check("t1_rx_data",  {24'd0, rx_data},     32'h12);
        check("t1_rx_valid", rv_cnt - rv0,         32'd1);
        check("t1_underrun", ur_cnt - ur0,         32'd0);
        check("t1_tx_ready", {31'd0, tx_ready},    32'd1);
        check("t1_miso_idle",{31'd0, miso},        32'd0);

        // Empty buffer: default word and one underrun pulse
        snap();
        m_words[0] = 8'h3C;
        spi_frame(1);
        check("t2_miso",     {24'd0, s_words[0]},  32'hFF);
        check("t2_underrun", ur_cnt - ur0,         32'd1);
        check("t2_rx_data",  {24'd0, rx_data},     32'h3C);
        check("t2_rx_valid", rv_cnt - rv0,         32'd1);

        // Two-word burst, second tx word written during word 1
        tx_write(8'h3C);
        snap();
        m_words[0] = 8'h55;
        m_words[1] = 8'hAA;
        fork
            spi_frame(2);
            begin
                repeat (30) @(negedge clk);
                tx_write(8'hC3);
            end
        join
        check("t3_miso0",    {24'd0, s_words[0]},        32'h3C);
        check("t3_miso1",    {24'd0, s_words[1]},        32'hC3);
        check("t3_rx_valid", rv_cnt - rv0,               32'd2);
        check("t3_rx0",      {24'd0, rx_log[rv0 % 8]},   32'h55);
        check("t3_rx1",      {24'd0, rx_log[(rv0+1) % 8]}, 32'hAA);
        check("t3_underrun", ur_cnt - ur0,               32'd0);
        check("t3_frame_err",fe_cnt - fe0,               32'd0);

        // Abort after four sclk cycles
        snap();
        ss = 1'b0;
        for (int i = 0; i < 4; i++) spi_bit(1'b1, r_dummy);
        #(H);
        check("t4_busy_mid", {31'd0, busy}, 32'd1);
        ss = 1'b1;
        #(H);
        check("t4_frame_err", fe_cnt - fe0,        32'd1);
        check("t4_rx_valid",  rv_cnt - rv0,        32'd0);
        check("t4_rx_held",   {24'd0, rx_data},    32'hAA);
        check("t4_busy_end",  {31'd0, busy},       32'd0);
        check("t4_miso",      {31'd0, miso},       32'd0);
        tx_write(8'hA5);
        snap();
        m_words[0] = 8'h12;
        spi_frame(1);
        check("t4b_miso",     {24'd0, s_words[0]}, 32'hA5);
        check("t4b_rx_data",  {24'd0, rx_data},    32'h12);
        check("t4b_frame_err",fe_cnt - fe0,        32'd0);

        // Reset mid-word with a word waiting in the buffer
        tx_write(8'h77);
        ss = 1'b0;
        repeat (6) @(negedge clk);
        tx_write(8'h66);
        check("t5_ready_full", {31'd0, tx_ready}, 32'd0);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, r_dummy);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_rx_data",  {24'd0, rx_data},     32'd0);
        check("t5_busy",     {31'd0, busy},        32'd0);
        check("t5_miso",     {31'd0, miso},        32'd0);
        check("t5_tx_ready", {31'd0, tx_ready},    32'd0);
        check("t5_pulses",   {29'd0, rx_valid, tx_underrun, frame_err}, 32'd0);
        ss = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rel_ready", {31'd0, tx_ready}, 32'd1);
        tx_write(8'hA5);
        snap();
        m_words[0] = 8'h12;
        spi_frame(1);
        check("t5_miso",      {24'd0, s_words[0]}, 32'hA5);
        check("t5_rx_after",  {24'd0, rx_data},    32'h12);
        check("t5_rx_valid",  rv_cnt - rv0,        32'd1);

        // tx_valid held on a full buffer while tx_data changes
        @(negedge clk);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data  = 8'hE7;
        @(negedge clk);
        check("t6_ready_full", {31'd0, tx_ready}, 32'd0);
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        m_words[0] = 8'h01;
        spi_frame(1);
        check("t6_miso",      {24'd0, s_words[0]}, 32'h5A);
        check("t6_rx_data",   {24'd0, rx_data},    32'h01);
        check("t6_tx_ready",  {31'd0, tx_ready},   32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
